// File: rtl/user_bus_arbiter.sv
// Two-master Wishbone arbiter (CPU = m0, DMA = m1) for the user memory slave port.
// Round-robin on ties, cycle-locked grants, and a stall timeout that returns an error pulse.
//
// state | meaning
// IDLE  | no owner, slave outputs driven to 0
// OWN0  | CPU owns the slave until m0_cyc_i drops
// OWN1  | DMA owns the slave until m1_cyc_i drops
`timescale 1ns/1ps
module user_bus_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 10
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   output logic [1:0]  grant_o,
   output logic [7:0]  timeout_cnt_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             err_q, err_d;
   logic [7:0]       tcnt_q, tcnt_d;
   logic             req0, req1;
   logic             stalled, hit;

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         stall_q <= '0;
         err_q   <= 1'b0;
         tcnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         stall_q <= stall_d;
         err_q   <= err_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // last_q: 0 = CPU was granted last, 1 = DMA; a tie goes to the other master
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (req0 && req1) begin
               if (last_q) begin
                  state_d = OWN0;
                  last_d  = 1'b0;
               end else begin
                  state_d = OWN1;
                  last_d  = 1'b1;
               end
            end else if (req0) begin
               state_d = OWN0;
               last_d  = 1'b0;
            end else if (req1) begin
               state_d = OWN1;
               last_d  = 1'b1;
            end
         end
         OWN0: if (!m0_cyc_i) state_d = IDLE;
         OWN1: if (!m1_cyc_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // strobe is masked during the error cycle so the slave sees the access abandoned
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_sel_o  = 4'd0;
      s_adr_o  = 32'd0;
      s_dat_o  = 32'd0;
      m0_dat_o = 32'd0;
      m1_dat_o = 32'd0;
      case (state_q)
         OWN0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i & ~err_q;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_dat_o = s_dat_i;
         end
         OWN1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i & ~err_q;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_dat_o = s_dat_i;
         end
         default: ;
      endcase
   end

   assign m0_ack_o = s_ack_i & (state_q == OWN0);
   assign m1_ack_o = s_ack_i & (state_q == OWN1);
   assign m0_err_o = err_q & (state_q == OWN0);
   assign m1_err_o = err_q & (state_q == OWN1);
   assign grant_o  = {state_q == OWN1, state_q == OWN0};
   assign timeout_cnt_o = tcnt_q;

   // an ack on the terminal stall cycle wins over the timeout
   assign stalled = (state_q != IDLE) & s_stb_o & ~s_ack_i;
   assign hit     = stalled & (stall_q == STALL_MAX) & (state_d == state_q);

   always_comb begin
      stall_d = stall_q;
      err_d   = hit;
      tcnt_d  = tcnt_q;
      if ((state_d != state_q) || s_ack_i || hit) begin
         stall_d = '0;
      end else if (stalled) begin
         stall_d = stall_q + 1'b1;
      end
      if (hit && (tcnt_q != 8'hFF)) begin
         tcnt_d = tcnt_q + 8'd1;
      end
   end

endmodule

// File: tb/tb_user_bus_arbiter.sv
// Directed bench for user_bus_arbiter: stimulus pushes expected acks/errors into a
// scoreboard queue, a negedge monitor pops and compares whenever a master sees ack/err.
`timescale 1ns/1ps
module tb_user_bus_arbiter;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni = 1'b0;
   logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
   logic [3:0]  m0_sel_i = 0;
   logic [31:0] m0_adr_i = 0, m0_dat_i = 0;
   logic        m0_ack_o, m0_err_o;
   logic [31:0] m0_dat_o;
   logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
   logic [3:0]  m1_sel_i = 0;
   logic [31:0] m1_adr_i = 0, m1_dat_i = 0;
   logic        m1_ack_o, m1_err_o;
   logic [31:0] m1_dat_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [31:0] s_dat_i = 0;
   logic        s_ack_i = 0;
   logic [1:0]  grant_o;
   logic [7:0]  timeout_cnt_o;

   typedef struct packed {
      logic        mst;
      logic        err;
      logic [31:0] dat;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   user_bus_arbiter #(.TIMEOUT(4), .CNT_W(10)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m0_dat_o(m0_dat_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .m1_dat_o(m1_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // monitor: any ack/err seen by a master must match the head of the scoreboard
   always @(negedge wb_clk_i) begin
      logic        any0, any1, got_m, got_e;
      logic [31:0] got_d;
      exp_t        e;
      any0 = m0_ack_o | m0_err_o;
      any1 = m1_ack_o | m1_err_o;
      if (any0 || any1) begin
         n_checks++;
         got_m = any1;
         got_e = m0_err_o | m1_err_o;
         got_d = any1 ? m1_dat_o : m0_dat_o;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got m%0d err=%0d dat=0x%08h, required no response",
                     got_m, got_e, got_d);
         end else begin
            e = sb_q.pop_front();
            if ((any0 && any1) || e.mst != got_m || e.err != got_e || (!e.err && e.dat != got_d)) begin
               n_fail++;
               $display("FAIL sb_resp: got m%0d err=%0d dat=0x%08h (both=%0d), required m%0d err=%0d dat=0x%08h",
                        got_m, got_e, got_d, any0 && any1, e.mst, e.err, e.dat);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic req(input int m, input logic [31:0] adr);
      if (m == 0) begin
         m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0; m0_sel_i = 4'hF; m0_adr_i = adr;
      end else begin
         m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_sel_i = 4'hF; m1_adr_i = adr;
      end
   endtask

   task automatic drop(input int m);
      if (m == 0) begin
         m0_cyc_i = 0; m0_stb_i = 0; m0_adr_i = 0;
      end else begin
         m1_cyc_i = 0; m1_stb_i = 0; m1_adr_i = 0;
      end
   endtask

   task automatic ack_beat(input int m, input logic [31:0] d);
      s_ack_i = 1;
      s_dat_i = d;
      sb_q.push_back('{mst: (m == 1), err: 1'b0, dat: d});
   endtask

   task automatic do_reset();
      wb_rst_ni = 0;
      tick();
      tick();
      wb_rst_ni = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      s_dat_i = 32'hDEAD_BEEF;
      tick();
      chk("rst_grant", 32'(grant_o), 32'd0);
      chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
      chk("rst_tcnt", 32'(timeout_cnt_o), 32'd0);
      chk("rst_m0_dat", m0_dat_o, 32'd0);
      wb_rst_ni = 1;
      tick();

      // single CPU read, slave acks two cycles after stb
      req(0, 32'h3800_0100);
      tick();
      chk("t1_grant", 32'(grant_o), 32'h1);
      chk("t1_s_stb", 32'(s_stb_o), 32'h1);
      chk("t1_s_adr", s_adr_o, 32'h3800_0100);
      tick();
      tick();
      ack_beat(0, 32'hCAFE_0001);
      chk("t1_m1_dat", m1_dat_o, 32'd0);
      tick();
      s_ack_i = 0;
      drop(0);
      tick();
      chk("t1_idle", 32'(grant_o), 32'h0);

      // first tie after reset goes to CPU, then one idle cycle, then DMA
      do_reset();
      req(0, 32'h3800_0200);
      req(1, 32'h3800_0300);
      tick();
      chk("t2_tie1", 32'(grant_o), 32'h1);
      ack_beat(0, 32'h0000_0201);
      tick();
      s_ack_i = 0;
      drop(0);
      tick();
      chk("t2_gap", 32'(grant_o), 32'h0);
      tick();
      chk("t2_dma", 32'(grant_o), 32'h2);
      ack_beat(1, 32'h0000_0301);
      tick();
      s_ack_i = 0;
      drop(1);
      tick();
      chk("t2_idle", 32'(grant_o), 32'h0);
      req(0, 32'h3800_0400);
      req(1, 32'h3800_0500);
      tick();
      chk("t2_tie2", 32'(grant_o), 32'h1);
      ack_beat(0, 32'h0000_0401);
      tick();
      s_ack_i = 0;
      drop(0);
      drop(1);
      tick();
      tick();

      // DMA 11-beat burst with CPU requesting throughout
      req(0, 32'h3800_0600);
      req(1, 32'h3800_1000);
      tick();
      chk("t3_grant", 32'(grant_o), 32'h2);
      for (int i = 0; i < 11; i++) begin
         ack_beat(1, 32'h0000_1000 + 32'(i));
         chk("t3_locked", 32'(grant_o), 32'h2);
         tick();
      end
      s_ack_i = 0;
      drop(1);
      chk("t3_hold", 32'(grant_o), 32'h2);
      tick();
      chk("t3_gap", 32'(grant_o), 32'h0);
      tick();
      chk("t3_cpu", 32'(grant_o), 32'h1);
      ack_beat(0, 32'h0000_0601);
      tick();
      s_ack_i = 0;
      drop(0);
      tick();
      tick();

      // timeout: error on the 5th stalled cycle with TIMEOUT = 4
      req(0, 32'h3800_0700);
      tick();
      chk("t4_grant", 32'(grant_o), 32'h1);
      tick();
      tick();
      tick();
      chk("t4_no_err_yet", 32'(m0_err_o), 32'h0);
      sb_q.push_back('{mst: 1'b0, err: 1'b1, dat: 32'd0});
      tick();
      chk("t4_err", 32'(m0_err_o), 32'h1);
      chk("t4_stb_masked", 32'(s_stb_o), 32'h0);
      chk("t4_tcnt", 32'(timeout_cnt_o), 32'h1);
      tick();
      chk("t4_err_clr", 32'(m0_err_o), 32'h0);
      chk("t4_stb_back", 32'(s_stb_o), 32'h1);
      drop(0);
      tick();
      tick();

      // ack on the terminal stall cycle beats the timeout
      req(0, 32'h3800_0800);
      tick();
      tick();
      tick();
      tick();
      ack_beat(0, 32'h5A5A_0005);
      tick();
      s_ack_i = 0;
      chk("t5_no_err", 32'(m0_err_o), 32'h0);
      chk("t5_tcnt", 32'(timeout_cnt_o), 32'h1);
      drop(0);
      tick();
      tick();

      // asynchronous reset in the middle of a DMA burst
      req(1, 32'h3800_2000);
      tick();
      chk("t6_grant", 32'(grant_o), 32'h2);
      ack_beat(1, 32'h0000_2000);
      tick();
      ack_beat(1, 32'h0000_2001);
      tick();
      req(0, 32'h3800_0900);
      s_ack_i = 1;
      s_dat_i = 32'h0000_2002;
      wb_rst_ni = 0;
      #1;
      chk("t6_s_cyc", 32'(s_cyc_o), 32'h0);
      chk("t6_grant0", 32'(grant_o), 32'h0);
      chk("t6_m1_ack", 32'(m1_ack_o), 32'h0);
      chk("t6_m1_dat", m1_dat_o, 32'h0);
      chk("t6_s_adr", s_adr_o, 32'h0);
      chk("t6_tcnt", 32'(timeout_cnt_o), 32'h0);
      s_ack_i = 0;
      drop(1);
      tick();
      wb_rst_ni = 1;
      chk("t6_still_idle", 32'(grant_o), 32'h0);
      tick();
      chk("t6_cpu", 32'(grant_o), 32'h1);
      ack_beat(0, 32'h0000_0901);
      tick();
      s_ack_i = 0;
      drop(0);
      tick();
      tick();

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
